naneye_stream_tx: RTL and testbench

Sensor-side transmitter for the NanEye-style serial pixel stream, i.e. the transmitting end of the link our RX decoder and deserializer consume. It takes parallel pixel words through a valid/ready handshake and frames them into a frame sync, then rows of start/data/stop pixel words, and Manchester-encodes the result onto a single wire. It is used for RX loopback and bench stimulus, and as a sensor emulator on the board. It runs entirely in the sampling clock domain.

---
 rtl/naneye_stream_tx.sv | 248 ++++++++++++++++++++++++
 tb/tb_naneye_stream_tx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/naneye_stream_tx.sv
// naneye_stream_tx
//   Sensor-side NanEye-style serial transmitter. Frames parallel pixel words
//   into frame sync, then rows of start/data/stop pixel words and a line gap
//   of Manchester '1' bits. The result is Manchester-encoded onto TX_DATA.
//   All logic runs on the rising edge of CLOCK.
//
// Ports:
//   CLOCK, RESET (async, active high)
//   START        single-cycle frame request, sampled only in IDLE
//   PIX_DATA/PIX_VALID/PIX_READY  pixel handshake (READY = 1-cycle strobe)
//   TP_SEL       selects the (row+col) test pattern
//   TX_DATA, TX_EN   serial line and frame-on-wire enable
//   BUSY, LINE_END, FRAME_DONE, UNDERRUN  status / pulse outputs
//
// Optional feature macro: TEST_PATTERN_EN (test-pattern generator).
// All outputs are registered and are derived from the next-state values.
module naneye_stream_tx #(
  parameter int unsigned D_WIDTH         = 10,
  parameter int unsigned C_ROWS          = 320,
  parameter int unsigned C_COLUMNS       = 320,
  parameter int unsigned HALF_BIT_CYCLES = 4,
  parameter int unsigned FSYNC_HALVES    = 24,
  parameter int unsigned LINE_GAP_BITS   = 8
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               START,
  input  logic [D_WIDTH-1:0] PIX_DATA,
  input  logic               PIX_VALID,
  output logic               PIX_READY,
  input  logic               TP_SEL,
  output logic               TX_DATA,
  output logic               TX_EN,
  output logic               BUSY,
  output logic               LINE_END,
  output logic               FRAME_DONE,
  output logic               UNDERRUN
);

  localparam int unsigned WORD_BITS = D_WIDTH + 2;
  localparam int unsigned BIT_MAX0  = (FSYNC_HALVES > WORD_BITS) ? FSYNC_HALVES : WORD_BITS;
  localparam int unsigned BIT_MAX   = (LINE_GAP_BITS > BIT_MAX0) ? LINE_GAP_BITS : BIT_MAX0;
  localparam int unsigned CYC_W     = (HALF_BIT_CYCLES > 1) ? $clog2(HALF_BIT_CYCLES) : 1;
  localparam int unsigned BIT_W     = (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;
  localparam int unsigned COL_W     = (C_COLUMNS > 1) ? $clog2(C_COLUMNS) : 1;
  localparam int unsigned ROW_W     = (C_ROWS > 1) ? $clog2(C_ROWS) : 1;

  typedef enum logic [2:0] {
    IDLE, FSYNC_H, FSYNC_L, PIXEL, LINE_GAP, DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;       // cycle within a half-bit
  logic               phase_q, phase_d;   // 0 = first half of a bit
  logic [BIT_W-1:0]   bit_q, bit_d;       // half index in FSYNC, bit index elsewhere
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [D_WIDTH:0]   sh_q, sh_d;         // {data, stop}; MSB is the current bit
  logic               pix_ready_q, pix_ready_d;
  logic               tx_data_q, tx_data_d;
  logic               tx_en_q, tx_en_d;
  logic               busy_q, busy_d;
  logic               line_end_q, line_end_d;
  logic               frame_done_q, frame_done_d;
  logic               underrun_q, underrun_d;
`ifdef TEST_PATTERN_EN
  logic               tp_q, tp_d;
`else
  logic               tp_sel_unused;
  assign tp_sel_unused = TP_SEL;
`endif

  logic half_end, bit_end, slot, active_d, bit_val;

  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    phase_d      = phase_q;
    bit_d        = bit_q;
    col_d        = col_q;
    row_d        = row_q;
    sh_d         = sh_q;
    underrun_d   = 1'b0;
`ifdef TEST_PATTERN_EN
    tp_d         = tp_q;
`endif
    half_end = (cyc_q == CYC_W'(HALF_BIT_CYCLES - 1));
    bit_end  = half_end & phase_q;
    // The accept slot is the first cycle of a start bit; PIX_READY is high here.
    slot     = (state_q == PIXEL) && (bit_q == '0) && !phase_q && (cyc_q == '0);

    if (state_q != IDLE && state_q != DONE)
      cyc_d = half_end ? '0 : cyc_q + CYC_W'(1);

    case (state_q)
      IDLE: begin
        if (START) begin
          state_d = FSYNC_H;
          cyc_d   = '0;
          phase_d = 1'b0;
          bit_d   = '0;
          col_d   = '0;
          row_d   = '0;
`ifdef TEST_PATTERN_EN
          tp_d    = TP_SEL;
`endif
        end
      end
      FSYNC_H, FSYNC_L: begin
        if (half_end) begin
          if (bit_q == BIT_W'(FSYNC_HALVES - 1)) begin
            bit_d   = '0;
            phase_d = 1'b0;
            col_d   = '0;
            state_d = (state_q == FSYNC_H) ? FSYNC_L : PIXEL;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      PIXEL: begin
        if (slot) begin
`ifdef TEST_PATTERN_EN
          if (tp_q) begin
            sh_d = {D_WIDTH'(row_q) + D_WIDTH'(col_q), 1'b0};
          end else if (PIX_VALID) begin
            sh_d = {PIX_DATA, 1'b0};
          end else begin
            sh_d       = '0;
            underrun_d = 1'b1;
          end
`else
          if (PIX_VALID) begin
            sh_d = {PIX_DATA, 1'b0};
          end else begin
            sh_d       = '0;
            underrun_d = 1'b1;
          end
`endif
        end
        if (half_end) phase_d = ~phase_q;
        if (bit_end) begin
          if (bit_q == BIT_W'(WORD_BITS - 1)) begin
            bit_d = '0;
            if (col_q == COL_W'(C_COLUMNS - 1)) begin
              col_d   = '0;
              state_d = LINE_GAP;
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
            // Start bit is a constant; shifting begins after the first data bit.
            if (bit_q != '0) sh_d = {sh_q[D_WIDTH-1:0], 1'b0};
          end
        end
      end
      LINE_GAP: begin
        if (half_end) phase_d = ~phase_q;
        if (bit_end) begin
          if (bit_q == BIT_W'(LINE_GAP_BITS - 1)) begin
            bit_d = '0;
            if (row_q == ROW_W'(C_ROWS - 1)) begin
              row_d   = '0;
              state_d = DONE;
            end else begin
              row_d   = row_q + ROW_W'(1);
              state_d = PIXEL;
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Registered outputs reflect the state about to be entered.
    active_d = (state_d == FSYNC_H) || (state_d == FSYNC_L) ||
               (state_d == PIXEL) || (state_d == LINE_GAP);
    busy_d   = active_d;
    tx_en_d  = active_d;
    bit_val  = (bit_d == '0) ? 1'b1 : sh_d[D_WIDTH];
    case (state_d)
      FSYNC_H:  tx_data_d = 1'b1;
      PIXEL:    tx_data_d = bit_val ^ phase_d;
      LINE_GAP: tx_data_d = ~phase_d;
      default:  tx_data_d = 1'b0;
    endcase
    pix_ready_d = (state_d == PIXEL) && (bit_d == '0) && !phase_d && (cyc_d == '0);
`ifdef TEST_PATTERN_EN
    if (tp_d) pix_ready_d = 1'b0;
`endif
    line_end_d   = (state_d == LINE_GAP) && (bit_d == BIT_W'(LINE_GAP_BITS - 1)) &&
                   phase_d && (cyc_d == CYC_W'(HALF_BIT_CYCLES - 1));
    frame_done_d = (state_d == DONE);
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      cyc_q        <= '0;
      phase_q      <= 1'b0;
      bit_q        <= '0;
      col_q        <= '0;
      row_q        <= '0;
      sh_q         <= '0;
      pix_ready_q  <= 1'b0;
      tx_data_q    <= 1'b0;
      tx_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      line_end_q   <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
`ifdef TEST_PATTERN_EN
      tp_q         <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      phase_q      <= phase_d;
      bit_q        <= bit_d;
      col_q        <= col_d;
      row_q        <= row_d;
      sh_q         <= sh_d;
      pix_ready_q  <= pix_ready_d;
      tx_data_q    <= tx_data_d;
      tx_en_q      <= tx_en_d;
      busy_q       <= busy_d;
      line_end_q   <= line_end_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
`ifdef TEST_PATTERN_EN
      tp_q         <= tp_d;
`endif
    end
  end

  assign PIX_READY  = pix_ready_q;
  assign TX_DATA    = tx_data_q;
  assign TX_EN      = tx_en_q;
  assign BUSY       = busy_q;
  assign LINE_END   = line_end_q;
  assign FRAME_DONE = frame_done_q;
  assign UNDERRUN   = underrun_q;

endmodule

// File: tb/tb_naneye_stream_tx.sv
`timescale 1ns/1ps
module tb_naneye_stream_tx;
  localparam int D = 10, ROWS = 2, COLS = 3, H = 2, FSH = 4, LG = 2;
  localparam int NCYC = 340;

  logic clk = 1'b0;
  logic rst, start, tp_sel, pix_valid;
  logic [D-1:0] pix_data;
  logic pix_ready, tx_data, tx_en, busy, line_end, frame_done, underrun;

  naneye_stream_tx #(
    .D_WIDTH(D), .C_ROWS(ROWS), .C_COLUMNS(COLS),
    .HALF_BIT_CYCLES(H), .FSYNC_HALVES(FSH), .LINE_GAP_BITS(LG)
  ) dut (
    .CLOCK(clk), .RESET(rst), .START(start), .PIX_DATA(pix_data),
    .PIX_VALID(pix_valid), .PIX_READY(pix_ready), .TP_SEL(tp_sel),
    .TX_DATA(tx_data), .TX_EN(tx_en), .BUSY(busy), .LINE_END(line_end),
    .FRAME_DONE(frame_done), .UNDERRUN(underrun)
  );

  always #5 clk = ~clk;

  int asserts = 0;
  int fails   = 0;

  logic tr_tx [NCYC];
  logic tr_busy [NCYC];
  logic tr_rdy [NCYC];
  logic tr_und [NCYC];
  logic tr_le [NCYC];
  logic tr_fd [NCYC];
  int n_busy, n_txen, n_rdy, n_und, n_le, n_fd;
  logic [D-1:0] pix_vals [6];
  logic         pix_ok [6];
  int restart_at = -1;

  // Pulse START and record NCYC cycles of outputs; k=0 is the first FSYNC_H cycle.
  task automatic run_frame();
    int n;
    n = 0;
    n_busy = 0; n_txen = 0; n_rdy = 0; n_und = 0; n_le = 0; n_fd = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < NCYC; k++) begin
      tr_tx[k] = tx_data; tr_busy[k] = busy; tr_rdy[k] = pix_ready;
      tr_und[k] = underrun; tr_le[k] = line_end; tr_fd[k] = frame_done;
      n_busy += int'(busy); n_txen += int'(tx_en); n_rdy += int'(pix_ready);
      n_und += int'(underrun); n_le += int'(line_end); n_fd += int'(frame_done);
      start = (k == restart_at);
      pix_data  = pix_vals[(n < 6) ? n : 5];
      pix_valid = pix_ok[(n < 6) ? n : 5];
      if (pix_ready) n++;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] o;
    #3;
    o = {pix_ready, tx_data, tx_en, busy, line_end, frame_done, underrun};
    asserts++;
    if (o !== 7'b0) begin fails++; $display("FAIL reset_outputs got=%b exp=%b", o, 7'b0); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    o = {pix_ready, tx_data, tx_en, busy, line_end, frame_done, underrun};
    asserts++;
    if (o !== 7'b0) begin fails++; $display("FAIL idle_after_reset got=%b exp=%b", o, 7'b0); end
  endtask

  task automatic test_frame();
    logic [15:0] fs;
    logic [7:0]  gap;
    run_frame();
    for (int i = 0; i < 16; i++) fs[15-i] = tr_tx[i];
    for (int i = 0; i < 8; i++) gap[7-i] = tr_tx[160+i];
    asserts++;
    if (n_busy !== 320) begin fails++; $display("FAIL busy_len got=%0d exp=320", n_busy); end
    asserts++;
    if (n_txen !== 320) begin fails++; $display("FAIL txen_len got=%0d exp=320", n_txen); end
    asserts++;
    if (tr_busy[0] !== 1'b1 || tr_busy[319] !== 1'b1 || tr_busy[320] !== 1'b0) begin
      fails++; $display("FAIL busy_edges got=%b%b%b exp=110", tr_busy[0], tr_busy[319], tr_busy[320]);
    end
    asserts++;
    if (fs !== 16'hFF00) begin fails++; $display("FAIL fsync got=%h exp=ff00", fs); end
    asserts++;
    if (gap !== 8'b11001100) begin fails++; $display("FAIL line_gap got=%b exp=11001100", gap); end
    asserts++;
    if (n_fd !== 1 || tr_fd[320] !== 1'b1) begin
      fails++; $display("FAIL frame_done got=%0d/%b exp=1/1", n_fd, tr_fd[320]);
    end
    asserts++;
    if (n_le !== 2 || tr_le[167] !== 1'b1 || tr_le[319] !== 1'b1) begin
      fails++; $display("FAIL line_end got=%0d/%b%b exp=2/11", n_le, tr_le[167], tr_le[319]);
    end
    asserts++;
    if (n_und !== 0) begin fails++; $display("FAIL no_underrun got=%0d exp=0", n_und); end
    asserts++;
    if (tr_tx[320] !== 1'b0 || tr_busy[339] !== 1'b0) begin
      fails++; $display("FAIL after_done got=%b%b exp=00", tr_tx[320], tr_busy[339]);
    end
  endtask

  task automatic test_pixel_word();
    logic [23:0] halves;
    logic [47:0] exp_w, got_w;
    halves = 24'b10_10_01_10_01_10_01_01_10_01_10_01;
    run_frame();
    for (int i = 0; i < 48; i++) begin
      got_w[47-i] = tr_tx[16+i];
      exp_w[47-i] = halves[23 - i/H];
    end
    asserts++;
    if (got_w !== exp_w) begin fails++; $display("FAIL pixel_2a5 got=%h exp=%h", got_w, exp_w); end
    asserts++;
    if (n_rdy !== 6) begin fails++; $display("FAIL ready_count got=%0d exp=6", n_rdy); end
    asserts++;
    if ({tr_rdy[16], tr_rdy[64], tr_rdy[112], tr_rdy[168], tr_rdy[216], tr_rdy[264]} !== 6'b111111) begin
      fails++; $display("FAIL ready_pos got=%b%b%b%b%b%b exp=111111", tr_rdy[16], tr_rdy[64],
                        tr_rdy[112], tr_rdy[168], tr_rdy[216], tr_rdy[264]);
    end
  endtask

  task automatic test_underrun();
    logic [23:0] halves;
    logic [47:0] exp_w, got_w;
    halves = 24'b10_01_01_01_01_01_01_01_01_01_01_01;
    pix_ok[1] = 1'b0;
    run_frame();
    pix_ok[1] = 1'b1;
    for (int i = 0; i < 48; i++) begin
      got_w[47-i] = tr_tx[64+i];
      exp_w[47-i] = halves[23 - i/H];
    end
    asserts++;
    if (n_und !== 1) begin fails++; $display("FAIL underrun_count got=%0d exp=1", n_und); end
    asserts++;
    if (tr_und[65] !== 1'b1) begin fails++; $display("FAIL underrun_pos got=%b exp=1", tr_und[65]); end
    asserts++;
    if (got_w !== exp_w) begin fails++; $display("FAIL underrun_data got=%h exp=%h", got_w, exp_w); end
    asserts++;
    if (n_busy !== 320) begin fails++; $display("FAIL underrun_len got=%0d exp=320", n_busy); end
  endtask

  task automatic test_start_ignored();
    restart_at = 100;
    run_frame();
    restart_at = -1;
    asserts++;
    if (n_fd !== 1) begin fails++; $display("FAIL restart_done got=%0d exp=1", n_fd); end
    asserts++;
    if (n_busy !== 320) begin fails++; $display("FAIL restart_len got=%0d exp=320", n_busy); end
  endtask

  task automatic test_reset_mid();
    logic [6:0] o;
    int nb;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (150) @(negedge clk);
    asserts++;
    if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy got=%b exp=1", busy); end
    #2 rst = 1'b1;
    #1;
    o = {pix_ready, tx_data, tx_en, busy, line_end, frame_done, underrun};
    asserts++;
    if (o !== 7'b0) begin fails++; $display("FAIL async_reset got=%b exp=%b", o, 7'b0); end
    @(negedge clk);
    rst = 1'b0;
    nb = 0;
    repeat (30) begin
      @(negedge clk);
      nb += int'(busy) + int'(tx_en) + int'(tx_data) + int'(frame_done);
    end
    asserts++;
    if (nb !== 0) begin fails++; $display("FAIL idle_after_abort got=%0d exp=0", nb); end
    run_frame();
    asserts++;
    if (n_busy !== 320) begin fails++; $display("FAIL frame_after_abort got=%0d exp=320", n_busy); end
  endtask

`ifdef TEST_PATTERN_EN
  task automatic test_pattern();
    int starts [6];
    logic [D-1:0] exp_v [6];
    logic [D-1:0] got_v;
    starts = '{16, 64, 112, 168, 216, 264};
    exp_v  = '{10'd0, 10'd1, 10'd2, 10'd1, 10'd2, 10'd3};
    tp_sel = 1'b1;
    for (int i = 0; i < 6; i++) pix_ok[i] = 1'b0;
    run_frame();
    tp_sel = 1'b0;
    for (int i = 0; i < 6; i++) pix_ok[i] = 1'b1;
    asserts++;
    if (n_rdy !== 0) begin fails++; $display("FAIL tp_ready got=%0d exp=0", n_rdy); end
    asserts++;
    if (n_und !== 0) begin fails++; $display("FAIL tp_underrun got=%0d exp=0", n_und); end
    for (int p = 0; p < 6; p++) begin
      for (int j = 1; j <= D; j++) got_v[D-j] = tr_tx[starts[p] + j*2*H];
      asserts++;
      if (got_v !== exp_v[p]) begin fails++; $display("FAIL tp_pix%0d got=%0d exp=%0d", p, got_v, exp_v[p]); end
    end
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; tp_sel = 1'b0; pix_valid = 1'b0; pix_data = '0;
    pix_vals = '{10'h2A5, 10'h155, 10'h3FF, 10'h000, 10'h0F0, 10'h30C};
    for (int i = 0; i < 6; i++) pix_ok[i] = 1'b1;
    test_reset();
    test_frame();
    test_pixel_word();
    test_underrun();
    test_start_ignored();
    test_reset_mid();
`ifdef TEST_PATTERN_EN
    test_pattern();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
